// File: rtl/pmcc_code_ram.sv
`default_nettype none
// ============================================================================
//  Module      : pmcc_code_ram
//  Description : Byte-addressed code store and instruction-fetch responder for
//                the PMC coprocessor. Returns the 32-bit little-endian window
//                starting at any byte PC, wrapping at the top of memory, and
//                exposes a req/gnt/rvalid word port for the SoC core to load
//                and read back code.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                fetch_en, pc_if       - fetch enable / fetch byte address
//                instr                 - registered fetch window
//                bus_req, bus_we, bus_addr, bus_be, bus_wdata - bus request
//                bus_gnt, bus_rvalid, bus_rdata               - bus response
//  Revision    : 1.0 - initial release
// ============================================================================
module pmcc_code_ram #(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_if,
    output logic [31:0]       instr,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [3:0]        bus_be,
    input  logic [31:0]       bus_wdata,
    output logic              bus_gnt,
    output logic              bus_rvalid,
    output logic [31:0]       bus_rdata
);

    localparam int c_WORD_W = ADDR_W - 2;
    localparam int c_WORDS  = DEPTH_BYTES / 4;

    // Storage and registered outputs
    logic [31:0] mem_q [c_WORDS];
    logic [31:0] mem_d [c_WORDS];
    logic [31:0] instr_q, instr_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic [c_WORD_W-1:0] w_fetch_word;
    logic [c_WORD_W-1:0] w_fetch_word_nxt;
    logic [c_WORD_W-1:0] w_bus_word;
    logic [63:0]         w_fetch_pair;
    logic [31:0]         w_fetch_window;
    logic                w_wr_en;
    logic                w_unused_addr_lsb;

    // Word access only: the two low address bits carry no meaning on the bus.
    assign w_unused_addr_lsb = ^bus_addr[1:0];

    // Writes stall while the coprocessor runs; reads are always granted.
    // This also guarantees a fetch and a write never happen in the same cycle.
    assign bus_gnt = bus_req & (~bus_we | ~fetch_en);
    assign w_wr_en = bus_gnt & bus_we;

    assign w_bus_word = bus_addr[ADDR_W-1:2];

    // Window spans the addressed word and its successor (modulo the store,
    // so the top word pairs with word 0), then is rotated right by the byte
    // offset inside the word.
    assign w_fetch_word     = pc_if[ADDR_W-1:2];
    assign w_fetch_word_nxt = w_fetch_word + c_WORD_W'(1);
    assign w_fetch_pair     = {mem_q[w_fetch_word_nxt], mem_q[w_fetch_word]};
    assign w_fetch_window   = w_fetch_pair[{pc_if[1:0], 3'b000} +: 32];

    always_comb begin
        for (int w = 0; w < c_WORDS; w++) begin
            mem_d[w] = mem_q[w];
        end
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_be[b]) begin
                    mem_d[w_bus_word][8*b +: 8] = bus_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        instr_d = instr_q;
        if (fetch_en) begin
            instr_d = w_fetch_window;
        end
    end

    // Every grant produces exactly one response next cycle; writes answer
    // with zero data, reads with the word as it stood at the grant edge.
    always_comb begin
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        if (bus_gnt) begin
            rvalid_d = 1'b1;
            rdata_d  = bus_we ? 32'h0 : mem_q[w_bus_word];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < c_WORDS; w++) begin
                mem_q[w] <= '0;
            end
            instr_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            for (int w = 0; w < c_WORDS; w++) begin
                mem_q[w] <= mem_d[w];
            end
            instr_q  <= instr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign instr      = instr_q;
    assign bus_rvalid = rvalid_q;
    assign bus_rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_pmcc_code_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmcc_code_ram
//  Description : Directed self-checking bench for pmcc_code_ram.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pmcc_code_ram;

    localparam int ADDR_W      = 8;
    localparam int DEPTH_BYTES = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_en;
    logic [ADDR_W-1:0] pc_if;
    logic [31:0]       instr;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pmcc_code_ram #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .ADDR_W     (ADDR_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_en  (fetch_en),
        .pc_if     (pc_if),
        .instr     (instr),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_gnt   (bus_gnt),
        .bus_rvalid(bus_rvalid),
        .bus_rdata (bus_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete bus transaction; waits (bounded) for grant, then checks
    // the response one cycle after the grant edge.
    task automatic bus_xfer(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int waited);
        @(negedge clk);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_be    = be;
        bus_wdata = wdata;
        #1;
        waited = 0;
        while (!bus_gnt && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check_val("gnt", {31'b0, bus_gnt}, 32'd1);
        @(posedge clk);
        #1;
        check_val(we ? "wr_rvalid" : "rd_rvalid", {31'b0, bus_rvalid}, 32'd1);
        rdata   = bus_rdata;
        bus_req = 1'b0;
        bus_we  = 1'b0;
        if (we) check_val("wr_rdata", bus_rdata, 32'h0);
    endtask

    task automatic fetch_chk(input string tag, input logic [ADDR_W-1:0] pc, input logic [31:0] exp);
        @(negedge clk);
        fetch_en = 1'b1;
        pc_if    = pc;
        @(posedge clk);
        #1;
        check_val(tag, instr, exp);
    endtask

    logic [31:0] rd;
    logic [31:0] exp_b2b [3];
    int          wt;

    initial begin
        rst_n     = 1'b0;
        fetch_en  = 1'b0;
        pc_if     = '0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_instr",  instr, 32'h0);
        check_val("rst_rvalid", {31'b0, bus_rvalid}, 32'h0);
        check_val("rst_rdata",  bus_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1) unaligned fetch across a word boundary
        bus_xfer(1'b1, 8'h00, 4'hF, 32'h44332211, rd, wt);
        bus_xfer(1'b1, 8'h04, 4'hF, 32'h88776655, rd, wt);
        fetch_chk("fetch_pc01", 8'h01, 32'h55443322);
        fetch_chk("fetch_pc00", 8'h00, 32'h44332211);

        // 2) wrap at top of memory
        @(negedge clk);
        fetch_en = 1'b0;
        bus_xfer(1'b1, 8'hFC, 4'hF, 32'hDDCCBBAA, rd, wt);
        bus_xfer(1'b1, 8'h00, 4'hF, 32'h04030201, rd, wt);
        fetch_chk("fetch_wrap_fe", 8'hFE, 32'h0201DDCC);
        fetch_chk("fetch_wrap_ff", 8'hFF, 32'h030201DD);

        // 3) byte enables, read with ignored low address bits
        @(negedge clk);
        fetch_en = 1'b0;
        bus_xfer(1'b1, 8'h10, 4'h5, 32'hFFFFFFFF, rd, wt);
        bus_xfer(1'b0, 8'h12, 4'h0, 32'h0, rd, wt);
        check_val("be_read", rd, 32'h00FF00FF);

        // 4) write stalls while fetching, lands once fetch_en drops
        @(negedge clk);
        fetch_en  = 1'b1;
        pc_if     = 8'h00;
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 8'h20;
        bus_be    = 4'hF;
        bus_wdata = 32'hCAFEF00D;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_val("stall_gnt", {31'b0, bus_gnt}, 32'h0);
            @(posedge clk);
            #1;
            check_val("stall_rvalid", {31'b0, bus_rvalid}, 32'h0);
            @(negedge clk);
        end
        fetch_en = 1'b0;
        #1;
        check_val("unstall_gnt", {31'b0, bus_gnt}, 32'd1);
        @(posedge clk);
        #1;
        check_val("unstall_rvalid", {31'b0, bus_rvalid}, 32'd1);
        bus_req = 1'b0;
        bus_we  = 1'b0;
        @(negedge clk);
        fetch_en = 1'b1;
        bus_xfer(1'b0, 8'h20, 4'h0, 32'h0, rd, wt);
        check_val("rd_fetching_wait", wt, 32'd0);
        check_val("stalled_wr_data", rd, 32'hCAFEF00D);

        // 5) instr holds with fetch disabled; back-to-back reads
        fetch_chk("fetch_pc04", 8'h04, 32'h88776655);
        @(negedge clk);
        fetch_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pc_if = 8'h11 + 8'(c * 37);
            @(posedge clk);
            #1;
            check_val("instr_hold", instr, 32'h88776655);
        end
        exp_b2b[0] = 32'h04030201;
        exp_b2b[1] = 32'h88776655;
        exp_b2b[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_req  = 1'b1;
            bus_we   = 1'b0;
            bus_addr = 8'(4 * i);
            #1;
            check_val("b2b_gnt", {31'b0, bus_gnt}, 32'd1);
            @(posedge clk);
            #1;
            check_val("b2b_rvalid", {31'b0, bus_rvalid}, 32'd1);
            check_val("b2b_rdata", bus_rdata, exp_b2b[i]);
        end
        @(negedge clk);
        bus_req = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_rvalid", {31'b0, bus_rvalid}, 32'h0);
        check_val("idle_rdata_hold", bus_rdata, 32'h00000000);

        // 6) reset between read grant and response consumption
        fetch_chk("pre_rst_fetch", 8'h00, 32'h04030201);
        @(negedge clk);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 8'h04;
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        #1;
        check_val("mid_rst_rvalid", {31'b0, bus_rvalid}, 32'h0);
        check_val("mid_rst_instr", instr, 32'h0);
        @(posedge clk);
        #1;
        check_val("rst_held_rvalid", {31'b0, bus_rvalid}, 32'h0);
        @(negedge clk);
        bus_req  = 1'b0;
        fetch_en = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_rvalid", {31'b0, bus_rvalid}, 32'h0);
        for (int a = 0; a < DEPTH_BYTES; a += 4) begin
            bus_xfer(1'b0, 8'(a), 4'h0, 32'h0, rd, wt);
            check_val("post_rst_mem", rd, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
